// File: rtl/imm_extender_pipe.sv
// imm_extender_pipe
//
// Pipelined immediate extender for the ARM datapath. The 24-bit instruction
// immediate field is decoded according to ImmSrc at pipe entry. The result
// (extended immediate, shifter carry-out and illegal-mode flag) is then carried
// through STAGES register stages with valid/ready flow control.
//
// Parameters
//   OUT_W   width of ExtImm (>= 32); bits above 31 follow each mode's rule
//   STAGES  number of register stages (1..4) = latency in cycles
//   ROT_EN  1: mode 0 decodes imm8 ror 2*rot; 0: mode 0 zero-extends imm8
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous; discards all in-flight entries
//   in_valid   Instr/ImmSrc valid
//   in_ready   block can accept this cycle
//   Instr      instruction bits [23:0]
//   ImmSrc     extension mode (0 rot-imm8, 1 imm12, 2 branch offset, 3 illegal)
//   out_valid  ExtImm/ShCarry/Ill valid
//   out_ready  consumer accepts this cycle
//   ExtImm     extended immediate
//   ShCarry    rotate carry-out (mode 0 only)
//   Ill        ImmSrc==3 was presented
module imm_extender_pipe #(
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int ROT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      Instr,
  input  logic [1:0]       ImmSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ExtImm,
  output logic             ShCarry,
  output logic             Ill
);

  // One pipe entry is packed as {ill, carry, imm}.
  localparam int ENTRY_W = OUT_W + 2;

  // ---------------------------------------------------------------------------
  // Entry decode
  // ---------------------------------------------------------------------------
  logic [31:0]      rotBase;
  logic [5:0]       rotAmt;
  logic [31:0]      rotVal;
  logic [OUT_W-1:0] entryImm;
  logic             entryCarry;
  logic             entryIll;

  assign rotBase = {24'b0, Instr[7:0]};
  assign rotAmt  = {1'b0, Instr[11:8], 1'b0};
  // Rotate right within 32 bits. With rotAmt==0 the left shift is by 32 and
  // contributes nothing, so no special case is needed.
  assign rotVal  = (rotBase >> rotAmt) | (rotBase << (6'd32 - rotAmt));

  always_comb begin
    entryImm   = '0;
    entryCarry = 1'b0;
    entryIll   = 1'b0;
    case (ImmSrc)
      2'd0: begin
        if (ROT_EN != 0) begin
          entryImm[31:0] = rotVal;
          // Carry-out only exists when a rotation actually took place.
          entryCarry     = (Instr[11:8] != 4'd0) && rotVal[31];
        end else begin
          entryImm[7:0] = Instr[7:0];
        end
      end
      2'd1: entryImm[11:0] = Instr[11:0];
      2'd2: begin
        // Branch offset: word offset scaled by 4, sign-extended to OUT_W.
        entryImm       = {OUT_W{Instr[23]}};
        entryImm[25:0] = {Instr, 2'b00};
      end
      default: entryIll = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]              stageValid;
  logic [STAGES-1:0][ENTRY_W-1:0] stageData;
  logic [STAGES-1:0]              feedValid;
  logic [STAGES-1:0][ENTRY_W-1:0] feedData;
  logic [STAGES-1:0]              loadOk;
  logic                           chainOk;

  // What each stage would capture: stage 0 takes the decoded input, every
  // later stage takes its predecessor.
  for (genvar gi = 0; gi < STAGES; gi++) begin : gFeed
    if (gi == 0) begin : gFirst
      assign feedValid[gi] = in_valid;
      assign feedData[gi]  = {entryIll, entryCarry, entryImm};
    end else begin : gNext
      assign feedValid[gi] = stageValid[gi-1];
      assign feedData[gi]  = stageData[gi-1];
    end
  end

  // A stage may load when it is empty or its contents are moving on. The
  // chain runs from the output back to stage 0, so a consumer accepting this
  // cycle frees space all the way up without a bubble.
  always_comb begin
    chainOk = out_ready;
    loadOk  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chainOk   = !stageValid[k] || chainOk;
      loadOk[k] = chainOk;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stageValid <= '0;
      stageData  <= '0;
    end else if (flush) begin
      // Only the valid bits clear; data registers keep their last contents.
      stageValid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (loadOk[k]) begin
          stageValid[k] <= feedValid[k];
          // Data only updates with a real entry, so idle outputs hold.
          if (feedValid[k]) begin
            stageData[k] <= feedData[k];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = !reset && !flush && loadOk[0];
  assign out_valid = stageValid[STAGES-1];
  assign {Ill, ShCarry, ExtImm} = stageData[STAGES-1];

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Bench for imm_extender_pipe. Three instances with different parameter sets
// share the same stimulus; each has its own occupancy/ordering scoreboard fed
// by an arithmetic reference model of the immediate rules.
module tb_imm_extender_pipe;

  localparam int ND = 3;
  localparam int CFG_OW  [ND] = '{32, 40, 36};
  localparam int CFG_ST  [ND] = '{2, 1, 4};
  localparam int CFG_ROT [ND] = '{1, 0, 1};
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] Instr = '0;
  logic [1:0]  ImmSrc = '0;

  logic        irA  [ND];
  logic        ovA  [ND];
  logic        cA   [ND];
  logic        illA [ND];
  logic [63:0] immA [ND];

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : gDut
    logic [CFG_OW[g]-1:0] extImm;
    logic inRdy, outVld, shC, ill;
    imm_extender_pipe #(
      .OUT_W (CFG_OW[g]),
      .STAGES(CFG_ST[g]),
      .ROT_EN(CFG_ROT[g])
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (inRdy),
      .Instr    (Instr),
      .ImmSrc   (ImmSrc),
      .out_valid(outVld),
      .out_ready(out_ready),
      .ExtImm   (extImm),
      .ShCarry  (shC),
      .Ill      (ill)
    );
    assign irA[g]  = inRdy;
    assign ovA[g]  = outVld;
    assign cA[g]   = shC;
    assign illA[g] = ill;
    assign immA[g] = 64'(extImm);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic checkBit(input string nm, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: immediate rules computed with plain integer arithmetic
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] imm;
    logic        c;
    logic        ill;
  } res_t;

  function automatic res_t model(input logic [23:0] ins, input logic [1:0] mode,
                                 input int ow, input int rotEn);
    res_t r;
    longint unsigned v;
    longint unsigned mask;
    longint s;
    int amt;
    r = '0;
    mask = (64'd1 << ow) - 64'd1;
    case (mode)
      2'd0: begin
        v = 64'(ins[7:0]);
        if (rotEn != 0) begin
          amt = 2 * int'(ins[11:8]);
          v = ((v >> amt) | (v << (32 - amt))) & 64'hFFFF_FFFF;
          r.c = (amt != 0) && v[31];
        end
        r.imm = v;
      end
      2'd1: r.imm = 64'(ins[11:0]);
      2'd2: begin
        s = longint'(64'(ins));
        if (ins[23]) s = s - (64'sd1 <<< 24);
        s = s * 64'sd4;
        r.imm = 64'(s) & mask;
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: samples on the falling edge what the next rising
  // edge will do, per instance.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    res_t r;
    int   acc;
  } sb_t;

  sb_t         sb [ND][64];
  int          hd [ND];
  int          cnt [ND];
  logic        prevStall [ND];
  logic [63:0] prevImm [ND];
  logic        prevC [ND];
  logic        prevIll [ND];
  int          cyc = 0;

  initial begin
    for (int d = 0; d < ND; d++) begin
      hd[d] = 0; cnt[d] = 0; prevStall[d] = 1'b0;
      prevImm[d] = '0; prevC[d] = 1'b0; prevIll[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int d = 0; d < ND; d++) begin
          cnt[d] = 0;
          prevStall[d] = 1'b0;
        end
      end else begin
        cyc++;
        for (int d = 0; d < ND; d++) begin
          sb_t  e;
          logic expOv;
          checkBit($sformatf("in_ready[%0d]", d), irA[d],
                   !flush && ((cnt[d] < CFG_ST[d]) || out_ready));
          if (prevStall[d]) begin
            checkBit($sformatf("hold_valid[%0d]", d), ovA[d], 1'b1);
            check($sformatf("hold_imm[%0d]", d), immA[d], prevImm[d]);
            checkBit($sformatf("hold_carry[%0d]", d), cA[d], prevC[d]);
            checkBit($sformatf("hold_ill[%0d]", d), illA[d], prevIll[d]);
          end
          e = sb[d][hd[d]];
          expOv = (cnt[d] > 0) && (cyc >= e.acc + CFG_ST[d]);
          checkBit($sformatf("out_valid[%0d] cyc %0d", d, cyc), ovA[d], expOv);
          if (ovA[d] && out_ready && cnt[d] > 0) begin
            check($sformatf("imm[%0d] cyc %0d", d, cyc), immA[d], e.r.imm);
            checkBit($sformatf("carry[%0d] cyc %0d", d, cyc), cA[d], e.r.c);
            checkBit($sformatf("ill[%0d] cyc %0d", d, cyc), illA[d], e.r.ill);
            hd[d] = (hd[d] + 1) % 64;
            cnt[d]--;
          end
          prevStall[d] = ovA[d] && !out_ready && !flush;
          prevImm[d] = immA[d];
          prevC[d] = cA[d];
          prevIll[d] = illA[d];
          if (flush) begin
            cnt[d] = 0;
          end else if (in_valid && irA[d] && cnt[d] < 64) begin
            e.r = model(Instr, ImmSrc, CFG_OW[d], CFG_ROT[d]);
            e.acc = cyc;
            sb[d][(hd[d] + cnt[d]) % 64] = e;
            cnt[d]++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed vectors: e0/c0 for OUT_W=32 ROT_EN=1, e1 for OUT_W=40 ROT_EN=0
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [23:0] ins;
    logic [1:0]  mode;
    logic [31:0] e0;
    logic        c0;
    logic [39:0] e1;
    logic        ill;
  } vec_t;

  vec_t tv [NV];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int delivered;

    tv[0]  = '{24'hE54D54, 2'd0, 32'h00001500, 1'b0, 40'h0000000054, 1'b0};
    tv[1]  = '{24'hE54D54, 2'd1, 32'h00000D54, 1'b0, 40'h0000000D54, 1'b0};
    tv[2]  = '{24'hE54D54, 2'd2, 32'hFF953550, 1'b0, 40'hFFFF953550, 1'b0};
    tv[3]  = '{24'h654D75, 2'd0, 32'h00001D40, 1'b0, 40'h0000000075, 1'b0};
    tv[4]  = '{24'h654D75, 2'd2, 32'h019535D4, 1'b0, 40'h00019535D4, 1'b0};
    tv[5]  = '{24'h000102, 2'd0, 32'h80000000, 1'b1, 40'h0000000002, 1'b0};
    tv[6]  = '{24'h000080, 2'd0, 32'h00000080, 1'b0, 40'h0000000080, 1'b0};
    tv[7]  = '{24'h123456, 2'd3, 32'h00000000, 1'b0, 40'h0000000000, 1'b1};
    tv[8]  = '{24'h123456, 2'd1, 32'h00000456, 1'b0, 40'h0000000456, 1'b0};
    tv[9]  = '{24'h0002FF, 2'd0, 32'hF000000F, 1'b1, 40'h00000000FF, 1'b0};
    tv[10] = '{24'h000F01, 2'd0, 32'h00000004, 1'b0, 40'h0000000001, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      checkBit($sformatf("rst_ov[%0d]", d), ovA[d], 1'b0);
      check($sformatf("rst_imm[%0d]", d), immA[d], 64'd0);
      checkBit($sformatf("rst_c[%0d]", d), cA[d], 1'b0);
      checkBit($sformatf("rst_ill[%0d]", d), illA[d], 1'b0);
    end
    #1 reset = 1'b0;
    nextCycle();
    for (int d = 0; d < ND; d++)
      checkBit($sformatf("post_rst_in_ready[%0d]", d), irA[d], 1'b1);

    // Table vectors streamed back to back with exact-latency checks
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) begin
        in_valid = 1'b1;
        Instr = tv[i].ins;
        ImmSrc = tv[i].mode;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 1 && i - 1 < NV) begin
        checkBit($sformatf("tbl1_ov %0d", i - 1), ovA[1], 1'b1);
        check($sformatf("tbl1_imm %0d", i - 1), immA[1], 64'(tv[i-1].e1));
        checkBit($sformatf("tbl1_c %0d", i - 1), cA[1], 1'b0);
        checkBit($sformatf("tbl1_ill %0d", i - 1), illA[1], tv[i-1].ill);
      end
      if (i >= 2) begin
        checkBit($sformatf("tbl0_ov %0d", i - 2), ovA[0], 1'b1);
        check($sformatf("tbl0_imm %0d", i - 2), immA[0], 64'(tv[i-2].e0));
        checkBit($sformatf("tbl0_c %0d", i - 2), cA[0], tv[i-2].c0);
        checkBit($sformatf("tbl0_ill %0d", i - 2), illA[0], tv[i-2].ill);
      end
      nextCycle();
    end
    repeat (6) nextCycle();

    // Backpressure: five entries against a stalled consumer
    out_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (k < 5);
      Instr = 24'hA00 + 24'(k);
      ImmSrc = 2'd1;
      @(negedge clk);
      if (in_valid && irA[0]) k++;
      nextCycle();
    end
    check("bp_accepts", 64'(k), 64'(CFG_ST[0]));
    @(negedge clk);
    checkBit("bp_in_ready_low", irA[0], 1'b0);
    checkBit("bp_out_valid", ovA[0], 1'b1);
    check("bp_head_imm", immA[0], 64'h0000_0A00);
    nextCycle();
    out_ready = 1'b1;
    delivered = 0;
    for (int t = 0; t < 30 && delivered < 5; t++) begin
      in_valid = (k < 5);
      Instr = 24'hA00 + 24'(k);
      @(negedge clk);
      if (ovA[0]) begin
        check($sformatf("bp_order %0d", delivered), immA[0], 64'h0A00 + 64'(delivered));
        delivered++;
      end
      if (in_valid && irA[0]) k++;
      nextCycle();
    end
    in_valid = 1'b0;
    check("bp_delivered", 64'(delivered), 64'd5);
    repeat (6) nextCycle();

    // Flush with a full pipe and input offered
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1;
      Instr = 24'($urandom);
      ImmSrc = 2'd0;
      nextCycle();
    end
    flush = 1'b1;
    Instr = 24'h000102;
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      checkBit($sformatf("flush_in_ready[%0d]", d), irA[d], 1'b0);
    nextCycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        checkBit($sformatf("flush_empty[%0d] t%0d", d, t), ovA[d], 1'b0);
      nextCycle();
    end
    in_valid = 1'b1;
    Instr = 24'h0002FF;
    ImmSrc = 2'd0;
    @(negedge clk);
    nextCycle();
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        checkBit($sformatf("flush_latency[%0d] n%0d", d, n), ovA[d], n == CFG_ST[d]);
      if (n == CFG_ST[0]) begin
        check("flush_post_imm", immA[0], 64'hF000_000F);
        checkBit("flush_post_c", cA[0], 1'b1);
      end
      nextCycle();
    end

    // Asynchronous reset mid-stream
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      Instr = 24'hE54D54;
      ImmSrc = 2'd2;
      nextCycle();
    end
    checkBit("pre_reset_ov", ovA[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checkBit($sformatf("arst_ov[%0d]", d), ovA[d], 1'b0);
      check($sformatf("arst_imm[%0d]", d), immA[d], 64'd0);
      checkBit($sformatf("arst_c[%0d]", d), cA[d], 1'b0);
      checkBit($sformatf("arst_ill[%0d]", d), illA[d], 1'b0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    nextCycle();
    for (int d = 0; d < ND; d++) begin
      checkBit($sformatf("arst_in_ready[%0d]", d), irA[d], 1'b1);
      checkBit($sformatf("arst_empty[%0d]", d), ovA[d], 1'b0);
    end
    repeat (4) nextCycle();

    // Randomized traffic with occasional flushes
    for (int t = 0; t < 3000; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      Instr = 24'($urandom);
      ImmSrc = 2'($urandom_range(0, 3));
      out_ready = (t % 400 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 60) == 0);
      nextCycle();
    end

    // Drain
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (12) nextCycle();
    for (int d = 0; d < ND; d++)
      check($sformatf("drain_left[%0d]", d), 64'(cnt[d]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
